pin_wiggle_checker: RTL

// - Receive end of the 16-pin counter link: samples the Pmod JA/JB pins driven
//   by the counting board, checks they follow a +1 binary sequence, and reports

---
 rtl/pin_wiggle_checker_pkg.sv | 13 +
 rtl/pin_sync_filter.sv | 52 +++++
 rtl/pin_wiggle_checker.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pin_wiggle_checker_pkg.sv
// Shared definitions for the pin wiggle checker.
// Holds the FSM state encoding and the default pin bus width.
package pin_wiggle_checker_pkg;

  localparam int unsigned W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/pin_sync_filter.sv
// Two-flop synchronizer plus stability filter for the incoming pin bus.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   pins_in [W]  - raw asynchronous pins
//   accept       - one-cycle pulse when a value has held for STABLE_CYCLES
//   v       [W]  - accepted value (the current candidate)
module pin_sync_filter
  import pin_wiggle_checker_pkg::*;
#(
  parameter int unsigned W             = W_DEFAULT,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pins_in,
  output logic         accept,
  output logic [W-1:0] v
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

  logic [W-1:0]  meta;
  logic [W-1:0]  s;
  logic [W-1:0]  cand;
  logic [SW-1:0] stab;

  // Synchronize, then require the synced value to hold before accepting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= '0;
      s      <= '0;
      cand   <= '0;
      stab   <= '0;
      accept <= 1'b0;
    end else begin
      meta   <= pins_in;
      s      <= meta;
      accept <= 1'b0;
      if (s != cand) begin
        cand <= s;
        stab <= '0;
      end else if (stab != SW'(STABLE_CYCLES)) begin
        stab   <= stab + SW'(1);
        // Pulse only on the step that reaches saturation.
        accept <= (stab == SW'(STABLE_CYCLES - 1));
      end
    end
  end

  assign v = cand;

endmodule

// File: rtl/pin_wiggle_checker.sv
// Receive-side checker for the 16-pin counter link.
// Verifies the filtered pin value follows a +1 sequence and reports status.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   pins_in [W]       - raw pins {jb7..jb0, ja7..ja0}
//   clear_stats       - pulse; clears err_count, wrap_count, bad_bits, stalled
//   locked, led       - high while tracking a clean count
//   stalled           - sticky, set when a locked count stops advancing
//   err_count [16]    - saturating mismatch count while locked
//   wrap_count [8]    - all-ones to zero transitions while locked
//   bad_bits [W]      - sticky OR of differing bits over locked mismatches
module pin_wiggle_checker
  import pin_wiggle_checker_pkg::*;
#(
  parameter int unsigned W              = W_DEFAULT,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned LOCK_RUN       = 4,
  parameter int unsigned LOSS_THRESH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pins_in,
  input  logic         clear_stats,
  output logic         locked,
  output logic         led,
  output logic         stalled,
  output logic [15:0]  err_count,
  output logic [7:0]   wrap_count,
  output logic [W-1:0] bad_bits
);

  localparam int unsigned RW = $clog2(LOCK_RUN + 1);
  localparam int unsigned MW = $clog2(LOSS_THRESH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          accept;
  logic [W-1:0]  v;
  state_t        state, state_d;
  logic [W-1:0]  ref_q;
  logic [RW-1:0] run_q;
  logic [MW-1:0] miss_q;
  logic [TW-1:0] timer_q;
  logic [W-1:0]  nxt;
  logic          eff, match, run_last, miss_last, timeout_hit;
  logic          ld_ref, run_clr, run_inc, miss_clr, miss_inc;
  logic          timer_clr, timer_inc, err_ev, wrap_ev, stall_ev;

  pin_sync_filter #(
    .W             (W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .pins_in (pins_in),
    .accept  (accept),
    .v       (v)
  );

  // A repeat of the reference (glitch and return) is not progress, except
  // in ACQUIRE where any accepted value seeds the reference.
  assign nxt         = ref_q + W'(1);
  assign eff         = accept && ((state == ST_ACQUIRE) || (v != ref_q));
  assign match       = (v == nxt);
  assign run_last    = (run_q == RW'(LOCK_RUN - 1));
  assign miss_last   = (miss_q == MW'(LOSS_THRESH - 1));
  assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_ACQUIRE;
    else       state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_ACQUIRE: if (eff) state_d = ST_TRACK;
      ST_TRACK:   if (eff && match && run_last) state_d = ST_LOCKED;
      ST_LOCKED: begin
        if (eff) begin
          if (!match && miss_last) state_d = ST_TRACK;
        end else if (timeout_hit) begin
          state_d = ST_TRACK;
        end
      end
      default:    state_d = ST_ACQUIRE;
    endcase
  end

  // Datapath and statistic strobes.
  always_comb begin
    ld_ref    = 1'b0;
    run_clr   = 1'b0;
    run_inc   = 1'b0;
    miss_clr  = 1'b0;
    miss_inc  = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    err_ev    = 1'b0;
    wrap_ev   = 1'b0;
    stall_ev  = 1'b0;
    unique case (state)
      ST_ACQUIRE: begin
        if (eff) begin
          ld_ref  = 1'b1;
          run_clr = 1'b1;
        end
      end
      ST_TRACK: begin
        if (eff) begin
          ld_ref = 1'b1;
          if (match) begin
            run_inc = 1'b1;
            if (run_last) begin
              miss_clr  = 1'b1;
              timer_clr = 1'b1;
            end
          end else begin
            run_clr = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (eff) begin
          ld_ref    = 1'b1;
          timer_clr = 1'b1;
          if (match) begin
            miss_clr = 1'b1;
            wrap_ev  = (v == '0);
          end else begin
            err_ev   = 1'b1;
            miss_inc = 1'b1;
            run_clr  = miss_last;
          end
        end else if (timeout_hit) begin
          stall_ev  = 1'b1;
          run_clr   = 1'b1;
          timer_clr = 1'b1;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Tracking registers and registered outputs; clear_stats beats any event.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q      <= '0;
      run_q      <= '0;
      miss_q     <= '0;
      timer_q    <= '0;
      locked     <= 1'b0;
      stalled    <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      bad_bits   <= '0;
    end else begin
      if (ld_ref) ref_q <= v;
      if (run_clr)      run_q <= '0;
      else if (run_inc) run_q <= run_q + RW'(1);
      if (miss_clr)      miss_q <= '0;
      else if (miss_inc) miss_q <= miss_q + MW'(1);
      if (timer_clr)      timer_q <= '0;
      else if (timer_inc) timer_q <= timer_q + TW'(1);
      locked <= (state_d == ST_LOCKED);
      if (clear_stats) begin
        stalled    <= 1'b0;
        err_count  <= '0;
        wrap_count <= '0;
        bad_bits   <= '0;
      end else begin
        if (err_ev) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          bad_bits <= bad_bits | (v ^ nxt);
        end
        if (wrap_ev)  wrap_count <= wrap_count + 8'd1;
        if (stall_ev) stalled    <= 1'b1;
      end
    end
  end

  assign led = locked;

endmodule
